// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN BCD stack core: keypad codes and FSM states.
package rpn_pkg;

  localparam logic [4:0] K_PLUS  = 5'b10000;
  localparam logic [4:0] K_MINUS = 5'b10001;
  localparam logic [4:0] K_BACKS = 5'b10010;
  localparam logic [4:0] K_ENTER = 5'b10011;
  localparam logic [4:0] K_UP    = 5'b10100;
  localparam logic [4:0] K_DOWN  = 5'b10101;
  localparam logic [4:0] K_NOP   = 5'b10110;
  localparam logic [4:0] K_CHS   = 5'b10111;

  typedef enum logic [1:0] {S_IDLE, S_ARITH, S_FIX, S_WRITE} state_t;

  // Codes 0..9 are digit keys
  function automatic logic is_digit(input logic [4:0] k);
    return k < 5'd10;
  endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// Single BCD digit add/subtract with carry/borrow; shared across all digit steps.
module bcd_digit_alu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       sub,
  output logic [3:0] d,
  output logic       cout
);

  logic [4:0] t;

  // 5-bit intermediate: add corrects >9, subtract corrects negative (bit 4 set)
  always_comb begin
    t    = 5'd0;
    d    = 4'd0;
    cout = 1'b0;
    if (sub) begin
      t    = {1'b0, a} - {1'b0, b} - {4'd0, cin};
      cout = t[4];
      d    = t[4] ? 4'(t + 5'd10) : t[3:0];
    end else begin
      t    = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      cout = (t > 5'd9);
      d    = cout ? 4'(t - 5'd10) : t[3:0];
    end
  end

endmodule

// File: rtl/rpn_bcd_stack_core.sv
// RPN calculator core: sign-magnitude BCD stack, digit-serial add/sub, display tap.
module rpn_bcd_stack_core
  import rpn_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            key_code,
  input  logic                  key_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  disp_neg,
  output logic [DEPTH_LOG2-1:0] disp_idx,
  output logic [DEPTH_LOG2-1:0] sp_out,
  output logic                  error
);

  localparam int MAG_W = 4 * DIGITS;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(DIGITS + 1);

  typedef struct packed {
    logic             neg;
    logic [MAG_W-1:0] mag;
  } entry_t;

  entry_t                stack [DEPTH];
  logic [DEPTH_LOG2-1:0] sp, disp_p, sp_inc, sp_dec;
  logic [CNT_W-1:0]      entry_cnt, dcnt;
  logic                  entry_open, err;
  state_t                state;
  logic [MAG_W-1:0]      op_a, op_b, res, res_next;
  logic                  carry, op_sub, res_neg, fix_neg;
  logic                  minus, full, last;
  logic [3:0]            alu_d;
  logic                  alu_cout;
  entry_t                x, y;

  assign sp_inc   = sp + 1'b1;
  assign sp_dec   = sp - 1'b1;
  assign x        = stack[sp];
  assign y        = stack[sp_dec];
  assign full     = (sp == {DEPTH_LOG2{1'b1}});
  assign minus    = (key_code == K_MINUS);
  assign last     = (dcnt == CNT_W'(DIGITS - 1));
  assign res_next = {alu_d, res[MAG_W-1:4]};

  bcd_digit_alu u_alu (
    .a    (op_a[3:0]),
    .b    (op_b[3:0]),
    .cin  (carry),
    .sub  (op_sub),
    .d    (alu_d),
    .cout (alu_cout)
  );

  // Key handling, stack updates and the ARITH/FIX/WRITE sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      sp         <= '0;
      stack[0]   <= '0;
      entry_cnt  <= '0;
      entry_open <= 1'b1;
      disp_p     <= '0;
      state      <= S_IDLE;
      busy       <= 1'b0;
      err        <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      res        <= '0;
      carry      <= 1'b0;
      op_sub     <= 1'b0;
      res_neg    <= 1'b0;
      fix_neg    <= 1'b0;
      dcnt       <= '0;
    end else begin
      case (state)
        S_IDLE: if (key_valid && key_code != K_NOP) begin
          err <= 1'b0;
          if (is_digit(key_code)) begin
            if (entry_open) begin
              if (entry_cnt < CNT_W'(DIGITS)) begin
                stack[sp].mag <= {x.mag[MAG_W-5:0], key_code[3:0]};
                entry_cnt     <= entry_cnt + 1'b1;
                disp_p        <= sp;
              end
            end else if (full) begin
              err <= 1'b1;
            end else begin
              // closed entry: implicit ENTER, then this digit starts the new X
              stack[sp_inc] <= '{neg: 1'b0, mag: MAG_W'(key_code[3:0])};
              sp            <= sp_inc;
              entry_cnt     <= CNT_W'(1);
              entry_open    <= 1'b1;
              disp_p        <= sp_inc;
            end
          end else begin
            case (key_code)
              K_BACKS: if (entry_open && entry_cnt != '0) begin
                stack[sp].mag <= x.mag >> 4;
                if ((x.mag >> 4) == '0) stack[sp].neg <= 1'b0;
                entry_cnt <= entry_cnt - 1'b1;
              end
              K_ENTER: if (full) begin
                err <= 1'b1;
              end else begin
                stack[sp_inc] <= '0;
                sp            <= sp_inc;
                entry_cnt     <= '0;
                entry_open    <= 1'b1;
                disp_p        <= sp_inc;
              end
              K_CHS: begin
                if (x.mag != '0) stack[sp].neg <= ~x.neg;
                entry_open <= 1'b0;
              end
              K_UP:   if (disp_p < sp) disp_p <= disp_p + 1'b1;
              K_DOWN: if (disp_p != '0) disp_p <= disp_p - 1'b1;
              K_PLUS, K_MINUS: if (sp == '0) begin
                err <= 1'b1;
              end else begin
                op_a    <= y.mag;
                op_b    <= x.mag;
                op_sub  <= y.neg != (x.neg ^ minus);
                res_neg <= y.neg;
                fix_neg <= x.neg ^ minus;
                carry   <= 1'b0;
                dcnt    <= '0;
                state   <= S_ARITH;
                busy    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_ARITH: begin
          res   <= res_next;
          op_a  <= op_a >> 4;
          op_b  <= op_b >> 4;
          carry <= alu_cout;
          dcnt  <= dcnt + 1'b1;
          if (last) begin
            dcnt <= '0;
            if (alu_cout && op_sub) begin
              // |Y|<|X|: negate the ten's-complement partial, sign follows X
              op_a    <= '0;
              op_b    <= res_next;
              carry   <= 1'b0;
              res_neg <= fix_neg;
              state   <= S_FIX;
            end else if (alu_cout) begin
              err   <= 1'b1;
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_WRITE;
            end
          end
        end
        S_FIX: begin
          res   <= res_next;
          op_b  <= op_b >> 4;
          carry <= alu_cout;
          dcnt  <= dcnt + 1'b1;
          if (last) begin
            dcnt  <= '0;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          stack[sp_dec] <= '{neg: res_neg && (res != '0), mag: res};
          sp            <= sp_dec;
          disp_p        <= sp_dec;
          entry_open    <= 1'b0;
          entry_cnt     <= CNT_W'(DIGITS);
          state         <= S_IDLE;
          busy          <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered display/status outputs, one cycle behind the internal state
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      disp_idx <= '0;
      sp_out   <= '0;
      error    <= 1'b0;
    end else begin
      disp_bcd <= stack[disp_p].mag;
      disp_neg <= stack[disp_p].neg;
      disp_idx <= disp_p;
      sp_out   <= sp;
      error    <= err;
    end
  end

endmodule

// File: tb/tb_rpn_bcd_stack_core.sv
// Bench for rpn_bcd_stack_core: integer-valued stack model, directed plus random keys.
module tb_rpn_bcd_stack_core;

  localparam int D     = 4;
  localparam int DL    = 4;
  localparam int MAXSP = (1 << DL) - 1;
  localparam int LIM   = 10000;

  localparam logic [4:0] PLUS  = 5'b10000;
  localparam logic [4:0] MINUS = 5'b10001;
  localparam logic [4:0] BACKS = 5'b10010;
  localparam logic [4:0] ENTER = 5'b10011;
  localparam logic [4:0] UP    = 5'b10100;
  localparam logic [4:0] DOWN  = 5'b10101;
  localparam logic [4:0] NOP   = 5'b10110;
  localparam logic [4:0] CHS   = 5'b10111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    key_code = 5'd0;
  logic          key_valid = 1'b0;
  logic          busy;
  logic [4*D-1:0] disp_bcd;
  logic          disp_neg;
  logic [DL-1:0] disp_idx;
  logic [DL-1:0] sp_out;
  logic          error;

  int checks = 0;
  int errors = 0;

  // reference model: stack of signed integers
  int mval [MAXSP+1];
  int msp, mdp, mcnt;
  bit mopen, merr;

  always #5 clk = ~clk;

  rpn_bcd_stack_core #(.DIGITS(D), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_valid (key_valid),
    .busy      (busy),
    .disp_bcd  (disp_bcd),
    .disp_neg  (disp_neg),
    .disp_idx  (disp_idx),
    .sp_out    (sp_out),
    .error     (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int m);
    logic [4*D-1:0] r;
    int v;
    r = '0;
    v = m;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    msp = 0; mdp = 0; mcnt = 0; mopen = 1; merr = 0;
    mval[0] = 0;
  endtask

  // Apply one key to the model; eb = expected busy cycles
  task automatic model(input logic [4:0] k, output int eb);
    int xv, yv, ax, ay;
    bit mn, sx, sy;
    eb = 0;
    if (k == NOP) return;
    merr = 0;
    if (k < 5'd10) begin
      if (mopen) begin
        if (mcnt < D) begin
          mval[msp] = mval[msp] * 10 + int'(k);
          mcnt++;
          mdp = msp;
        end
      end else if (msp == MAXSP) merr = 1;
      else begin
        msp++; mval[msp] = int'(k); mcnt = 1; mopen = 1; mdp = msp;
      end
    end else begin
      case (k)
        BACKS: if (mopen && mcnt > 0) begin mval[msp] = mval[msp] / 10; mcnt--; end
        ENTER: if (msp == MAXSP) merr = 1;
               else begin msp++; mval[msp] = 0; mcnt = 0; mopen = 1; mdp = msp; end
        CHS:   begin mval[msp] = -mval[msp]; mopen = 0; end
        UP:    if (mdp < msp) mdp++;
        DOWN:  if (mdp > 0) mdp--;
        PLUS, MINUS: if (msp == 0) merr = 1;
        else begin
          mn = (k == MINUS);
          xv = mval[msp]; yv = mval[msp-1];
          ax = iabs(xv); ay = iabs(yv);
          sy = (yv < 0); sx = (xv < 0) ^ mn;
          if (sy == sx && ay + ax >= LIM) begin
            merr = 1; eb = D;
          end else begin
            eb = (sy != sx && ay < ax) ? 2*D+1 : D+1;
            mval[msp-1] = yv + (mn ? -xv : xv);
            msp--; mdp = msp; mopen = 0; mcnt = D;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_state();
    chk("sp_out", 32'(sp_out), 32'(msp));
    chk("disp_idx", 32'(disp_idx), 32'(mdp));
    chk("disp_bcd", 32'(disp_bcd), 32'(to_bcd(iabs(mval[mdp]))));
    chk("disp_neg", 32'(disp_neg), 32'(mval[mdp] < 0));
    chk("error", 32'(error), 32'(merr));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  // Press a key, count busy cycles while spraying ignored keys, then compare
  task automatic do_key(input logic [4:0] k);
    int n, eb;
    model(k, eb);
    @(negedge clk); key_code = k; key_valid = 1'b1;
    @(negedge clk); key_valid = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      key_code  = 5'($urandom_range(0, 23));
      key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
    end
    chk("busy_cycles", 32'(n), 32'(eb));
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; key_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(disp_bcd), 32'd0);
    chk("rst_sp", 32'(sp_out), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int r;
    logic [4:0] k;
    model_reset();

    // entry and backspace
    do_reset();
    do_key(5'd1); do_key(5'd2); do_key(5'd3);
    chk("entry_123", 32'(disp_bcd), 32'h0123);
    do_key(BACKS);
    chk("backs_12", 32'(disp_bcd), 32'h0012);

    // subtract with borrow -> FIX path
    do_reset();
    do_key(5'd5); do_key(ENTER); do_key(5'd8); do_key(MINUS);
    chk("sub_res", 32'(disp_bcd), 32'h0003);
    chk("sub_neg", 32'(disp_neg), 32'd1);

    // add overflow, then error cleared by next key
    do_reset();
    repeat (4) do_key(5'd9);
    do_key(ENTER); do_key(5'd1); do_key(PLUS);
    chk("ovf_err", 32'(error), 32'd1);
    chk("ovf_sp", 32'(sp_out), 32'd1);
    do_key(5'd2);
    chk("ovf_clr", 32'(error), 32'd0);

    // stack full
    do_reset();
    repeat (15) do_key(ENTER);
    chk("full_sp", 32'(sp_out), 32'd15);
    do_key(ENTER);
    chk("full_err", 32'(error), 32'd1);

    // -7 + 7 normalises to +0; display pointer saturation
    do_reset();
    do_key(5'd7); do_key(CHS); do_key(ENTER); do_key(5'd7); do_key(PLUS);
    chk("zero_neg", 32'(disp_neg), 32'd0);
    do_key(ENTER); do_key(ENTER);
    repeat (3) do_key(DOWN);
    chk("down_sat", 32'(disp_idx), 32'd0);
    repeat (3) do_key(UP);
    chk("up_sat", 32'(disp_idx), 32'd2);

    // reset in the middle of arithmetic
    do_reset();
    do_key(5'd5); do_key(ENTER); do_key(5'd8);
    @(negedge clk); key_code = MINUS; key_valid = 1'b1;
    @(negedge clk); key_valid = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_sp", 32'(sp_out), 32'd0);
    chk("mid_bcd", 32'(disp_bcd), 32'd0);
    model_reset();
    @(negedge clk);
    check_state();

    // random keys against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      k = 5'($urandom_range(0, 9));
      else if (r < 55) k = ENTER;
      else if (r < 62) k = PLUS;
      else if (r < 69) k = MINUS;
      else if (r < 75) k = CHS;
      else if (r < 81) k = BACKS;
      else if (r < 88) k = UP;
      else if (r < 94) k = DOWN;
      else             k = NOP;
      do_key(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
